waveform_timer_ctrl: RTL

//   Control FSM that drives the shift/count datapath register.
//   - Watches the serial data line for a start pattern.
//   - Asserts shift_ena for SHIFT_LEN cycles so the datapath shifts in the delay value.
//   - Asserts count_ena until the datapath reports done_counting.
//   - Raises done and holds it until the host acknowledges.

---
 rtl/waveform_timer_ctrl.sv | 93 +++++++++
 1 files changed

// File: rtl/waveform_timer_ctrl.sv
// Control FSM for the shift/count delay datapath: finds a start pattern on the
// serial line, shifts in the delay, runs the countdown, then waits for a host ack.
module waveform_timer_ctrl #(
  parameter int                 PAT_LEN   = 4,
  parameter logic [PAT_LEN-1:0] PATTERN   = 4'b1101,
  parameter int                 SHIFT_LEN = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       data,
  input  logic       done_counting,
  input  logic       ack,
  output logic       shift_ena,
  output logic       count_ena,
  output logic       counting,
  output logic       done,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int FW = $clog2(PAT_LEN + 1);
  localparam int CW = (SHIFT_LEN > 1) ? $clog2(SHIFT_LEN) : 1;
  localparam logic [FW-1:0] FILL_MAX = FW'(PAT_LEN);
  localparam logic [FW-1:0] FILL_THR = FW'(PAT_LEN - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SHIFT_LEN - 1);

  state_t             state;
  state_t             state_nxt;
  logic [PAT_LEN-1:0] hist;
  logic [PAT_LEN-1:0] window;
  logic [FW-1:0]      fill;
  logic [CW-1:0]      shift_cnt;
  logic               match;

  // The bit arriving this edge completes the window, so it counts toward fill.
  assign window = {hist[PAT_LEN-2:0], data};
  assign match  = (fill >= FILL_THR) && (window == PATTERN);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (match) state_nxt = SHIFT;
      SHIFT:   if (shift_cnt == CNT_LAST) state_nxt = COUNT;
      COUNT:   if (done_counting) state_nxt = DONE;
      DONE:    if (ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      hist      <= '0;
      fill      <= '0;
      shift_cnt <= '0;
      shift_ena <= 1'b0;
      count_ena <= 1'b0;
      counting  <= 1'b0;
      done      <= 1'b0;
      state_dbg <= 2'd0;
    end else begin
      state     <= state_nxt;
      shift_ena <= (state_nxt == SHIFT);
      count_ena <= (state_nxt == COUNT);
      counting  <= (state_nxt == COUNT);
      done      <= (state_nxt == DONE);
      state_dbg <= state_nxt;
      case (state)
        IDLE: begin
          hist <= window;
          if (fill != FILL_MAX) fill <= fill + 1'b1;
          if (match) shift_cnt <= '0;
        end
        SHIFT: shift_cnt <= shift_cnt + 1'b1;
        DONE: begin
          if (ack) begin
            hist <= '0;
            fill <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
